multi_clock_gen: RTL

MULTI_CLOCK_GEN -- requirements
Module: multi_clock_gen

---
 rtl/multi_clock_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/multi_clock_gen.sv
// Multi-channel programmable clock generator: each channel divides clk by a
// configurable period with programmable high time and start delay.
module multi_clock_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_sel,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clock,
    output logic [NUM_CH-1:0] running,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, DELAY, RUN, DRAIN} state_t;

    logic cfg_ok;

    assign cfg_ok = cfg_we && (cfg_period != '0) && (int'(cfg_sel) < NUM_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx;
        logic [CNT_W-1:0] pend_p, pend_h, pend_d;
        logic [CNT_W-1:0] act_p, act_h, act_d;
        logic [CNT_W-1:0] eff_p, eff_h, eff_d;
        logic             active_run, wrap, load, clk_q, run_q;

        assign load       = cfg_ok && (cfg_sel == CH_W'(i));
        assign active_run = (state == RUN) || (state == DRAIN);
        assign wrap       = active_run && (cnt == act_p - CNT_W'(1));

        // Config only changes while idle or on the wrap edge, so a period is never cut short.
        always_comb begin
            eff_p    = act_p;
            eff_h    = act_h;
            eff_d    = act_d;
            state_nx = state;
            cnt_nx   = cnt;
            if (state == IDLE || wrap) begin
                eff_p = pend_p;
                eff_h = pend_h;
                eff_d = pend_d;
            end
            case (state)
                IDLE: begin
                    if (enable[i]) begin
                        if (eff_d != '0) begin
                            state_nx = DELAY;
                            cnt_nx   = CNT_W'(1);
                        end else begin
                            state_nx = RUN;
                            cnt_nx   = '0;
                        end
                    end
                end
                DELAY: begin
                    if (!enable[i]) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt >= act_d) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    cnt_nx = wrap ? '0 : cnt + CNT_W'(1);
                    if (!enable[i]) begin
                        state_nx = wrap ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    cnt_nx = wrap ? '0 : cnt + CNT_W'(1);
                    if (enable[i]) begin
                        state_nx = RUN;
                    end else if (wrap) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= IDLE;
                cnt    <= '0;
                clk_q  <= 1'b0;
                run_q  <= 1'b0;
                pend_p <= CNT_W'(2);
                pend_h <= CNT_W'(1);
                pend_d <= '0;
                act_p  <= CNT_W'(2);
                act_h  <= CNT_W'(1);
                act_d  <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                act_p <= eff_p;
                act_h <= eff_h;
                act_d <= eff_d;
                // Outputs lag the counter by one cycle so clock is a clean register.
                clk_q <= active_run && (cnt < act_h);
                run_q <= (state != IDLE);
                if (load) begin
                    pend_p <= cfg_period;
                    pend_h <= cfg_high;
                    pend_d <= cfg_phase;
                end
            end
        end

        assign clock[i]   = clk_q;
        assign running[i] = run_q;
    end

endmodule
